ql_sdram_arbiter: RTL and testbench

// - Slot scheduler sharing the single SDRAM port among four QL requesters: video fetch, microdrive read, CPU, data_io download.
// - Runs on clk21 and derives the bus phase and clkref internally.
// - Alternates video slots and CPU slots, one bus period (SLOT_LEN clocks) each.
// - Drives the sdram command inputs, latches read data and returns a one-clock ack per requester.

---
 rtl/ql_sdram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ql_sdram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ql_sdram_arbiter.sv
// QL SDRAM slot scheduler: alternating video/CPU bus slots on clk21, one access per slot.
// Optional QL_SLOT_STEAL_EN hands idle video slots to the CPU-side requesters.
module ql_sdram_arbiter #(
   parameter int ADDR_W     = 25,
   parameter int SLOT_LEN   = 8,
   parameter int DATA_PHASE = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   input  logic              mdv_req,
   input  logic [ADDR_W-1:0] mdv_addr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [1:0]        cpu_ds,
   input  logic [15:0]       cpu_din,
   input  logic              dio_req,
   input  logic [ADDR_W-1:0] dio_addr,
   input  logic [15:0]       dio_din,
   output logic              vid_ack,
   output logic              mdv_ack,
   output logic              cpu_ack,
   output logic              dio_ack,
   output logic [15:0]       rd_data,
   output logic              video_cycle,
   output logic              clkref,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              sd_we,
   output logic              sd_oe,
   output logic [1:0]        sd_ds,
   output logic [15:0]       sd_din,
   input  logic [15:0]       sdram_dout
);

   localparam int PH_W = $clog2(SLOT_LEN);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_LEN - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(SLOT_LEN / 2);
   localparam logic [PH_W-1:0] PH_ACK  = PH_W'(DATA_PHASE - 1);
   localparam logic [PH_W-1:0] PH_DATA = PH_W'(DATA_PHASE);

   // one-hot grant, bit order matches {dio, cpu, mdv, vid}
   localparam logic [3:0] GNT_VID = 4'b0001;
   localparam logic [3:0] GNT_MDV = 4'b0010;
   localparam logic [3:0] GNT_CPU = 4'b0100;
   localparam logic [3:0] GNT_DIO = 4'b1000;

   logic [PH_W-1:0]   phase;
   logic [3:0]        gnt;
   logic [3:0]        gnt_nxt;
   logic              gnt_rd;
   logic [ADDR_W-1:0] addr_nxt;
   logic              we_nxt;
   logic              oe_nxt;
   logic [1:0]        ds_nxt;
   logic [15:0]       din_nxt;

   assign clkref = (phase < PH_HALF);

   always_comb begin
      gnt_nxt = 4'b0000;
      if (video_cycle) begin
         if (mdv_req)
            gnt_nxt = GNT_MDV;
         else if (vid_req)
            gnt_nxt = GNT_VID;
`ifdef QL_SLOT_STEAL_EN
         else if (dio_req)
            gnt_nxt = GNT_DIO;
         else if (cpu_req)
            gnt_nxt = GNT_CPU;
`endif
      end else begin
         if (dio_req)
            gnt_nxt = GNT_DIO;
         else if (cpu_req)
            gnt_nxt = GNT_CPU;
      end
   end

   // Idle slots keep the last address and write data on the bus.
   always_comb begin
      addr_nxt = sd_addr;
      we_nxt   = 1'b0;
      oe_nxt   = 1'b0;
      ds_nxt   = 2'b11;
      din_nxt  = sd_din;
      case (gnt_nxt)
         GNT_VID: begin
            addr_nxt = vid_addr;
            oe_nxt   = 1'b1;
         end
         GNT_MDV: begin
            addr_nxt = mdv_addr;
            oe_nxt   = 1'b1;
         end
         GNT_CPU: begin
            addr_nxt = cpu_addr;
            we_nxt   = cpu_we;
            oe_nxt   = !cpu_we;
            ds_nxt   = cpu_ds;
            din_nxt  = cpu_din;
         end
         GNT_DIO: begin
            addr_nxt = dio_addr;
            we_nxt   = 1'b1;
            din_nxt  = dio_din;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase       <= '0;
         video_cycle <= 1'b0;
         gnt         <= 4'b0000;
         gnt_rd      <= 1'b0;
         sd_addr     <= '0;
         sd_we       <= 1'b0;
         sd_oe       <= 1'b0;
         sd_ds       <= 2'b11;
         sd_din      <= '0;
         rd_data     <= '0;
         {dio_ack, cpu_ack, mdv_ack, vid_ack} <= 4'b0000;
      end else begin
         phase <= phase + PH_W'(1);
         if (phase == PH_LAST)
            video_cycle <= !video_cycle;
         if (phase == '0) begin
            gnt     <= gnt_nxt;
            gnt_rd  <= oe_nxt;
            sd_addr <= addr_nxt;
            sd_we   <= we_nxt;
            sd_oe   <= oe_nxt;
            sd_ds   <= ds_nxt;
            sd_din  <= din_nxt;
         end
         // Registered one cycle early so the pulse lines up with DATA_PHASE.
         {dio_ack, cpu_ack, mdv_ack, vid_ack} <= (phase == PH_ACK) ? gnt : 4'b0000;
         if (phase == PH_DATA && gnt_rd)
            rd_data <= sdram_dout;
      end
   end

endmodule

// File: tb/tb_ql_sdram_arbiter.sv
// Bench for ql_sdram_arbiter: vector table of slot scenarios plus hand sequences, ack scoreboard.
module tb_ql_sdram_arbiter;

   localparam logic [3:0] ID_VID = 4'b0001;
   localparam logic [3:0] ID_MDV = 4'b0010;
   localparam logic [3:0] ID_CPU = 4'b0100;
   localparam logic [3:0] ID_DIO = 4'b1000;
`ifdef QL_SLOT_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif

   logic        clk, rst;
   logic        vid_req, mdv_req, cpu_req, dio_req, cpu_we;
   logic [24:0] vid_addr, mdv_addr, cpu_addr, dio_addr;
   logic [1:0]  cpu_ds;
   logic [15:0] cpu_din, dio_din;
   logic        vid_ack, mdv_ack, cpu_ack, dio_ack;
   logic [15:0] rd_data, sd_din, sdram_dout;
   logic        video_cycle, clkref, sd_we, sd_oe;
   logic [24:0] sd_addr;
   logic [1:0]  sd_ds;

   typedef struct {
      logic [3:0]  id;
      int          cyc;
      logic [24:0] addr;
      logic        we;
      logic        oe;
      logic [1:0]  ds;
      logic [15:0] din;
      bit          chk_din;
      bit          is_rd;
   } exp_t;

   typedef struct {
      bit              vc;
      logic [3:0]      req;
      logic            we;
      logic [1:0]      ds;
      int              n;
      logic [3:0][3:0] ids;
      logic [3:0][7:0] lats;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[12];
   int          n_vec = 0, n_err = 0, cyc = 0;
   logic [2:0]  tb_ph;
   logic        tb_vc;
   logic [15:0] rd_model = 16'h0000;
   bit          rd_pending = 1'b0;
   bit          hold_cpu = 1'b0;

   ql_sdram_arbiter #(.ADDR_W(25), .SLOT_LEN(8), .DATA_PHASE(6)) dut (
      .clk(clk), .reset(rst),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .mdv_req(mdv_req), .mdv_addr(mdv_addr),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds), .cpu_din(cpu_din),
      .dio_req(dio_req), .dio_addr(dio_addr), .dio_din(dio_din),
      .vid_ack(vid_ack), .mdv_ack(mdv_ack), .cpu_ack(cpu_ack), .dio_ack(dio_ack),
      .rd_data(rd_data), .video_cycle(video_cycle), .clkref(clkref),
      .sd_addr(sd_addr), .sd_we(sd_we), .sd_oe(sd_oe), .sd_ds(sd_ds), .sd_din(sd_din),
      .sdram_dout(sdram_dout)
   );

   function automatic logic [15:0] mem_f(input logic [24:0] a);
      return a[15:0] ^ {7'b0, a[24:16]} ^ 16'hBEEE;
   endfunction

   // SDRAM returns valid data only at phase 6; garbage elsewhere
   assign sdram_dout = (tb_ph == 3'd6) ? mem_f(sd_addr) : 16'hDEAD;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_ph <= 3'd0;
         tb_vc <= 1'b0;
      end else begin
         tb_ph <= tb_ph + 3'd1;
         if (tb_ph == 3'd7) tb_vc <= ~tb_vc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      n_vec++;
      if (act !== req_v) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req_v, cyc);
      end
   endtask

   function automatic exp_t mk_exp(input logic [3:0] id, input int c);
      exp_t e;
      e.id = id; e.cyc = c; e.addr = '0; e.we = 1'b0; e.oe = 1'b1; e.ds = 2'b11;
      e.din = '0; e.chk_din = 1'b0; e.is_rd = 1'b1;
      case (id)
         ID_VID: e.addr = vid_addr;
         ID_MDV: e.addr = mdv_addr;
         ID_CPU: begin
            e.addr = cpu_addr; e.we = cpu_we; e.oe = !cpu_we; e.ds = cpu_ds;
            e.din = cpu_din; e.chk_din = 1'b1; e.is_rd = !cpu_we;
         end
         ID_DIO: begin
            e.addr = dio_addr; e.we = 1'b1; e.oe = 1'b0; e.din = dio_din;
            e.chk_din = 1'b1; e.is_rd = 1'b0;
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic vec_t mkv(input bit vc, input logic [3:0] req, input logic we,
                                input logic [1:0] ds, input int n,
                                input logic [3:0] i0, input int l0, input logic [3:0] i1, input int l1,
                                input logic [3:0] i2, input int l2, input logic [3:0] i3, input int l3);
      vec_t v;
      v.vc = vc; v.req = req; v.we = we; v.ds = ds; v.n = n;
      v.ids[0] = i0; v.ids[1] = i1; v.ids[2] = i2; v.ids[3] = i3;
      v.lats[0] = 8'(l0); v.lats[1] = 8'(l1); v.lats[2] = 8'(l2); v.lats[3] = 8'(l3);
      return v;
   endfunction

   // One clock: sample at negedge, score acks, then step past the next posedge.
   task automatic tick();
      logic [3:0] seen;
      exp_t       e;
      @(negedge clk);
      seen = {dio_ack, cpu_ack, mdv_ack, vid_ack};
      chk("video_cycle", {31'b0, video_cycle}, {31'b0, tb_vc});
      chk("clkref", {31'b0, clkref}, {31'b0, (tb_ph < 3'd4)});
      if (rd_pending) begin
         chk("rd_data", {16'b0, rd_data}, {16'b0, rd_model});
         rd_pending = 1'b0;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         n_vec++; n_err++;
         $display("FAIL missed_ack: id %b got none, required at cycle %0d", exp_q[0].id, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (seen != 4'b0000) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("ack_id", {28'b0, seen}, {28'b0, e.id});
            chk("sd_addr", {7'b0, sd_addr}, {7'b0, e.addr});
            chk("sd_we", {31'b0, sd_we}, {31'b0, e.we});
            chk("sd_oe", {31'b0, sd_oe}, {31'b0, e.oe});
            chk("sd_ds", {30'b0, sd_ds}, {30'b0, e.ds});
            if (e.chk_din) chk("sd_din", {16'b0, sd_din}, {16'b0, e.din});
            if (e.is_rd) rd_model = mem_f(e.addr);
            rd_pending = 1'b1;
         end else begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ack: got %b at cycle %0d, required none", seen, cyc);
         end
      end
      @(posedge clk);
      #1;
      if (seen[0]) vid_req = 1'b0;
      if (seen[1]) mdv_req = 1'b0;
      if (seen[2] && !hold_cpu) cpu_req = 1'b0;
      if (seen[3]) dio_req = 1'b0;
   endtask

   task automatic wait_slot(input bit vc);
      for (int k = 0; k < 40 && !(tb_ph == 3'd0 && tb_vc == vc); k++) tick();
   endtask

   task automatic drain();
      for (int k = 0; k < 64 && exp_q.size() > 0; k++) tick();
      if (exp_q.size() > 0) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d acks outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      {dio_req, cpu_req, mdv_req, vid_req} = 4'b0000;
   endtask

   initial begin
      int c0;
      rst = 1'b1;
      {dio_req, cpu_req, mdv_req, vid_req} = 4'b0000;
      cpu_we = 1'b0; cpu_ds = 2'b11; cpu_din = '0; dio_din = '0;
      vid_addr = '0; mdv_addr = '0; cpu_addr = '0; dio_addr = '0;

      vecs[0]  = mkv(0, ID_CPU, 0, 2'b01, 1, ID_CPU, 6, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(0, ID_CPU, 1, 2'b10, 1, ID_CPU, 6, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mkv(0, ID_DIO, 0, 2'b11, 1, ID_DIO, 6, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mkv(0, ID_DIO | ID_CPU, 0, 2'b11, 2, ID_DIO, 6, ID_CPU, STEAL ? 14 : 22, 0, 0, 0, 0);
      vecs[4]  = mkv(1, ID_VID, 0, 2'b11, 1, ID_VID, 6, 0, 0, 0, 0, 0, 0);
      vecs[5]  = mkv(1, ID_MDV, 0, 2'b11, 1, ID_MDV, 6, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mkv(1, ID_MDV | ID_VID, 0, 2'b11, 2, ID_MDV, 6, ID_VID, 22, 0, 0, 0, 0);
      vecs[7]  = mkv(1, ID_CPU, 1, 2'b11, 1, ID_CPU, STEAL ? 6 : 14, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mkv(0, ID_VID, 0, 2'b11, 1, ID_VID, 14, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mkv(0, ID_CPU | ID_MDV, 0, 2'b10, 2, ID_CPU, 6, ID_MDV, 14, 0, 0, 0, 0);
      vecs[10] = mkv(1, 4'b1111, 1, 2'b01, 4, ID_MDV, 6, ID_DIO, 14, ID_VID, 22, ID_CPU, 30);
      vecs[11] = mkv(1, ID_DIO, 0, 2'b11, 1, ID_DIO, STEAL ? 6 : 14, 0, 0, 0, 0, 0, 0);

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_video_cycle", {31'b0, video_cycle}, 32'd0);
      chk("rst_clkref", {31'b0, clkref}, 32'd1);
      chk("rst_acks", {28'b0, dio_ack, cpu_ack, mdv_ack, vid_ack}, 32'd0);
      chk("rst_sd_we", {31'b0, sd_we}, 32'd0);
      chk("rst_sd_oe", {31'b0, sd_oe}, 32'd0);
      chk("rst_sd_ds", {30'b0, sd_ds}, 32'd3);
      chk("rst_sd_addr", {7'b0, sd_addr}, 32'd0);
      chk("rst_sd_din", {16'b0, sd_din}, 32'd0);
      chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         wait_slot(vecs[i].vc);
         vid_addr = 25'h000100 + 25'(i);
         mdv_addr = 25'h0A0200 + 25'(i * 3);
         cpu_addr = 25'h010000 + 25'(i * 5);
         dio_addr = 25'h1F0000 + 25'(i);
         cpu_din  = 16'h1000 + 16'(i);
         dio_din  = 16'h5A00 + 16'(i);
         cpu_we   = vecs[i].we;
         cpu_ds   = vecs[i].ds;
         {dio_req, cpu_req, mdv_req, vid_req} = vecs[i].req;
         c0 = cyc;
         for (int k = 0; k < vecs[i].n; k++)
            exp_q.push_back(mk_exp(vecs[i].ids[k], c0 + int'(vecs[i].lats[k])));
         drain();
      end

      // CPU read: command held for the whole slot, BEEF captured
      wait_slot(0);
      cpu_addr = 25'h010000; cpu_we = 1'b0; cpu_ds = 2'b01; cpu_req = 1'b1;
      exp_q.push_back(mk_exp(ID_CPU, cyc + 6));
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("hold_sd_oe", {31'b0, sd_oe}, 32'd1);
         chk("hold_sd_ds", {30'b0, sd_ds}, 32'd1);
         chk("hold_sd_we", {31'b0, sd_we}, 32'd0);
      end
      tick();
      chk("idle_sd_oe", {31'b0, sd_oe}, 32'd0);
      chk("idle_sd_ds", {30'b0, sd_ds}, 32'd3);
      chk("rd_beef", {16'b0, rd_data}, 32'h0000BEEF);
      drain();

      // late request at phase 1 misses this slot
      wait_slot(0);
      tick();
      cpu_addr = 25'h0123AB; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_req = 1'b1;
      exp_q.push_back(mk_exp(ID_CPU, cyc + (STEAL ? 13 : 21)));
      drain();

      // cpu_req held with no video traffic
      hold_cpu = 1'b1;
      wait_slot(0);
      cpu_addr = 25'h004444; cpu_we = 1'b1; cpu_ds = 2'b10; cpu_din = 16'hC0DE; cpu_req = 1'b1;
      c0 = cyc;
      if (STEAL) begin
         for (int k = 0; k < 4; k++) exp_q.push_back(mk_exp(ID_CPU, c0 + 6 + 8 * k));
      end else begin
         for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(ID_CPU, c0 + 6 + 16 * k));
      end
      drain();
      hold_cpu = 1'b0;
      repeat (16) tick();

      // reset in the middle of a granted CPU read
      wait_slot(0);
      cpu_addr = 25'h0077F0; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_req = 1'b1;
      repeat (3) tick();
      chk("pre_rst_sd_oe", {31'b0, sd_oe}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_sd_oe", {31'b0, sd_oe}, 32'd0);
      chk("mid_rst_sd_we", {31'b0, sd_we}, 32'd0);
      chk("mid_rst_rd_data", {16'b0, rd_data}, 32'd0);
      chk("mid_rst_sd_addr", {7'b0, sd_addr}, 32'd0);
      rd_model = 16'h0000;
      rd_pending = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      exp_q.push_back(mk_exp(ID_CPU, cyc + 6));
      drain();
      repeat (16) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
